// File: rtl/adjust_ctrl_pkg.sv
// Shared types and widths for the brightness-adjust frame sequencer.
package adjust_ctrl_pkg;

   localparam int PIX_W       = 8;
   localparam int FRAME_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RCV,
      PREFETCH,
      LOAD,
      REQ_SND,
      STORE,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/adjust_frame_ctrl_watchdog.sv
// Handshake watchdog: counts cycles spent waiting and flags expiry after TIMEOUT cycles.
module ack_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   // expired is raised during the TIMEOUT-th waiting cycle, so the FSM leaves after exactly TIMEOUT cycles
   assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/adjust_frame_ctrl.sv
// Frame sequencer: latches adjust parameters, streams the input image into the pipeline,
// then drains the pipeline output into the output image RAM, with status and a handshake watchdog.
module adjust_frame_ctrl
   import adjust_ctrl_pkg::*;
#(
   parameter int PIXEL_NUM = 16384,
   parameter int ADDR_W    = 14,
   parameter int TIMEOUT   = 4096
) (
   input  logic                   clk,
   input  logic                   xrst,
   input  logic                   start,
   input  logic [PIX_W-1:0]       cfg_from_v,
   input  logic [PIX_W-1:0]       cfg_to_v,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic [PIX_W-1:0]       adjust_from_v,
   output logic [PIX_W-1:0]       adjust_to_v,
   output logic                   in_rd,
   output logic [ADDR_W-1:0]      in_addr,
   input  logic [PIX_W-1:0]       in_rdata,
   input  logic                   rcv_req,
   output logic                   rcv_ack,
   output logic [PIX_W-1:0]       pixel_in,
   output logic                   snd_req,
   input  logic                   snd_ack,
   input  logic [PIX_W-1:0]       pixel_out,
   output logic                   out_we,
   output logic [ADDR_W-1:0]      out_addr,
   output logic [PIX_W-1:0]       out_wdata
);

   // One spare bit so PIXEL_NUM == 2**ADDR_W is still representable
   localparam int IDX_W = ADDR_W + 1;
   localparam logic [IDX_W-1:0] PIX_LAST  = IDX_W'(PIXEL_NUM - 1);
   localparam logic [IDX_W-1:0] PIX_TOTAL = IDX_W'(PIXEL_NUM);

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] ld_idx;
   logic [IDX_W-1:0] ld_idx_inc;
   logic [IDX_W-1:0] cap_idx;
   logic             capture;
   logic             wd_enable;
   logic             wd_expired;

   assign ld_idx_inc = ld_idx + IDX_W'(1);
   assign wd_enable  = (state == WAIT_RCV) || (state == REQ_SND);
   assign capture    = ((state == REQ_SND) && snd_ack) || ((state == STORE) && (cap_idx != PIX_TOTAL));

   ack_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (xrst),
      .clear   (!wd_enable),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A handshake seen in the expiry cycle still wins over the timeout
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start) state_next = WAIT_RCV;
         WAIT_RCV: begin
            if (rcv_req)         state_next = PREFETCH;
            else if (wd_expired) state_next = ERR;
         end
         PREFETCH: state_next = LOAD;
         LOAD:     if (ld_idx == PIX_LAST) state_next = REQ_SND;
         REQ_SND:  begin
            if (snd_ack)         state_next = STORE;
            else if (wd_expired) state_next = ERR;
         end
         STORE:    if (cap_idx == PIX_TOTAL) state_next = DONE;
         DONE:     state_next = IDLE;
         ERR:      state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      rcv_ack  = (state == LOAD);
      pixel_in = (state == LOAD) ? in_rdata : '0;
      snd_req  = (state == REQ_SND);
      in_rd    = 1'b0;
      in_addr  = '0;
      if (state == PREFETCH) begin
         in_rd = 1'b1;
      end else if ((state == LOAD) && (ld_idx_inc < PIX_TOTAL)) begin
         in_rd   = 1'b1;
         in_addr = ld_idx_inc[ADDR_W-1:0];
      end
   end

   // Pixel indices and the registered output RAM write port
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         ld_idx    <= '0;
         cap_idx   <= '0;
         out_we    <= 1'b0;
         out_addr  <= '0;
         out_wdata <= '0;
      end else begin
         ld_idx <= (state == LOAD) ? ld_idx_inc : '0;
         out_we <= capture;
         if (capture) begin
            cap_idx   <= cap_idx + IDX_W'(1);
            out_addr  <= cap_idx[ADDR_W-1:0];
            out_wdata <= pixel_out;
         end else if ((state != REQ_SND) && (state != STORE)) begin
            cap_idx <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         adjust_from_v <= '0;
         adjust_to_v   <= '0;
         err           <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            adjust_from_v <= cfg_from_v;
            adjust_to_v   <= cfg_to_v;
            err           <= 1'b0;
         end
         if (state_next == ERR) begin
            err <= 1'b1;
         end
         if (state == DONE) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_adjust_frame_ctrl.sv
// Self-checking bench for adjust_frame_ctrl with RAM models, a +50 pipeline model and a write scoreboard.
module tb_adjust_frame_ctrl;

   localparam int PN = 16;
   localparam int AW = 4;
   localparam int TO = 32;

   logic          clk = 1'b0;
   logic          xrst;
   logic          start;
   logic [7:0]    cfg_from_v;
   logic [7:0]    cfg_to_v;
   logic          busy;
   logic          done;
   logic          err;
   logic [15:0]   frame_cnt;
   logic [7:0]    adjust_from_v;
   logic [7:0]    adjust_to_v;
   logic          in_rd;
   logic [AW-1:0] in_addr;
   logic [7:0]    in_rdata = 8'd0;
   logic          rcv_req;
   logic          rcv_ack;
   logic [7:0]    pixel_in;
   logic          snd_req;
   logic          snd_ack = 1'b0;
   logic [7:0]    pixel_out = 8'd0;
   logic          out_we;
   logic [AW-1:0] out_addr;
   logic [7:0]    out_wdata;

   logic [7:0]  in_mem  [PN];
   logic [7:0]  out_mem [PN];
   logic [7:0]  in_q[$];
   logic [11:0] out_q[$];
   logic [7:0]  rx_q[$];

   int         errors = 0;
   int         checks = 0;
   int         done_cnt = 0;
   int         writes = 0;
   logic       no_ack = 1'b0;
   logic       chk_adjust = 1'b0;
   logic [7:0] exp_from = 8'd0;
   logic [7:0] exp_to = 8'd0;

   always #5 clk = ~clk;

   adjust_frame_ctrl #(
      .PIXEL_NUM (PN),
      .ADDR_W    (AW),
      .TIMEOUT   (TO)
   ) dut (
      .clk           (clk),
      .xrst          (xrst),
      .start         (start),
      .cfg_from_v    (cfg_from_v),
      .cfg_to_v      (cfg_to_v),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .frame_cnt     (frame_cnt),
      .adjust_from_v (adjust_from_v),
      .adjust_to_v   (adjust_to_v),
      .in_rd         (in_rd),
      .in_addr       (in_addr),
      .in_rdata      (in_rdata),
      .rcv_req       (rcv_req),
      .rcv_ack       (rcv_ack),
      .pixel_in      (pixel_in),
      .snd_req       (snd_req),
      .snd_ack       (snd_ack),
      .pixel_out     (pixel_out),
      .out_we        (out_we),
      .out_addr      (out_addr),
      .out_wdata     (out_wdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Synchronous-read input RAM and write-only output RAM
   always @(posedge clk) begin
      if (in_rd) in_rdata <= in_mem[in_addr];
      if (out_we) out_mem[out_addr] <= out_wdata;
   end

   // Pipeline model: buffers received pixels, answers snd_req after 5 cycles, adds 50
   always @(posedge clk) begin
      int lat;
      int left;
      snd_ack <= 1'b0;
      if (!busy) begin
         rx_q.delete();
         lat = 0;
         left = 0;
         pixel_out <= 8'd0;
      end else begin
         if (rcv_ack) rx_q.push_back(pixel_in);
         if (left > 0) begin
            pixel_out <= (rx_q.size() > 0) ? rx_q.pop_front() + 8'd50 : 8'd0;
            left--;
         end else if (snd_req && !no_ack) begin
            lat++;
            if (lat == 5) begin
               snd_ack   <= 1'b1;
               pixel_out <= (rx_q.size() > 0) ? rx_q.pop_front() + 8'd50 : 8'd0;
               left = PN - 1;
               lat = 0;
            end
         end else begin
            lat = 0;
         end
      end
   end

   // Monitor: input stream, write scoreboard, parameter stability, done count
   initial begin
      int run;
      run = 0;
      forever begin
         @(negedge clk);
         if (xrst) begin
            run = 0;
         end else begin
            if (done) done_cnt++;
            if (rcv_ack) begin
               run++;
               checkOutput("pixel_in", pixel_in, (in_q.size() > 0) ? in_q.pop_front() : 32'h1FF);
            end else if (run != 0) begin
               checkOutput("rcv_ack_run", run, PN);
               run = 0;
            end
            if (out_we) begin
               writes++;
               checkOutput("out_write", {out_addr, out_wdata}, (out_q.size() > 0) ? out_q.pop_front() : 32'hFFFF);
            end
            if (busy && chk_adjust) begin
               checkOutput("adjust_from_v", adjust_from_v, exp_from);
               checkOutput("adjust_to_v", adjust_to_v, exp_to);
            end
         end
      end
   end

   // Loads a ramp frame, queues its expectations and pulses start; entered and left on a negedge
   task automatic applyStimulus(input logic [7:0] base, input logic [7:0] from_v, input logic [7:0] to_v, input bit expect_out);
      for (int k = 0; k < PN; k++) begin
         logic [7:0] v;
         v = base + 8'(k);
         in_mem[k] = v;
         in_q.push_back(v);
         if (expect_out) out_q.push_back({4'(k), 8'(v + 8'd50)});
      end
      cfg_from_v = from_v;
      cfg_to_v   = to_v;
      exp_from   = from_v;
      exp_to     = to_v;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_seen", done, 1);
   endtask

   task automatic applyReset();
      xrst = 1'b1;
      repeat (2) @(negedge clk);
      xrst = 1'b0;
      in_q.delete();
      out_q.delete();
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int n;
      int req_cycles;
      int w0;
      xrst = 1'b1;
      start = 1'b0;
      cfg_from_v = 8'd0;
      cfg_to_v = 8'd0;
      rcv_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_frame_cnt", frame_cnt, 0);
      checkOutput("rst_adjust_from", adjust_from_v, 0);
      checkOutput("rst_adjust_to", adjust_to_v, 0);
      checkOutput("rst_in_rd", in_rd, 0);
      checkOutput("rst_in_addr", in_addr, 0);
      checkOutput("rst_rcv_ack", rcv_ack, 0);
      checkOutput("rst_pixel_in", pixel_in, 0);
      checkOutput("rst_snd_req", snd_req, 0);
      checkOutput("rst_out_we", out_we, 0);
      checkOutput("rst_out_addr", out_addr, 0);
      checkOutput("rst_out_wdata", out_wdata, 0);
      xrst = 1'b0;
      @(negedge clk);
      rcv_req = 1'b1;
      chk_adjust = 1'b1;

      $display("[TB] nominal frame, parameter latch, start while busy");
      applyStimulus(8'd0, 8'd50, 8'd100, 1'b1);
      cfg_from_v = 8'd10;
      cfg_to_v   = 8'd20;
      n = 0;
      while (!rcv_ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("load_reached", rcv_ack, 1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(300);
      @(negedge clk);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("frame_cnt_1", frame_cnt, 1);
      repeat (10) @(negedge clk);
      checkOutput("done_count_1", done_cnt, 1);
      checkOutput("out_q_drained", out_q.size(), 0);
      checkOutput("out_mem_0", out_mem[0], 50);
      checkOutput("out_mem_15", out_mem[15], 65);

      $display("[TB] watchdog on missing snd_ack");
      no_ack = 1'b1;
      applyStimulus(8'd30, 8'd30, 8'd40, 1'b0);
      n = 0;
      req_cycles = 0;
      while (!err && n < 300) begin
         @(negedge clk);
         if (snd_req) req_cycles++;
         n++;
      end
      checkOutput("err_set", err, 1);
      checkOutput("snd_req_in_err", snd_req, 0);
      checkOutput("req_snd_cycles", req_cycles, TO);
      @(negedge clk);
      checkOutput("busy_after_err", busy, 0);
      checkOutput("err_sticky", err, 1);
      checkOutput("done_count_wd", done_cnt, 1);
      checkOutput("frame_cnt_wd", frame_cnt, 1);
      no_ack = 1'b0;
      applyStimulus(8'd100, 8'd60, 8'd70, 1'b1);
      checkOutput("err_cleared", err, 0);
      checkOutput("busy_restart", busy, 1);
      waitDone(300);
      @(negedge clk);
      checkOutput("frame_cnt_2", frame_cnt, 2);
      checkOutput("out_q_drained_2", out_q.size(), 0);

      $display("[TB] reset mid-LOAD");
      applyStimulus(8'd200, 8'd5, 8'd6, 1'b1);
      n = 0;
      while (!(rcv_ack && pixel_in == 8'd207) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput("pixel7_reached", pixel_in, 207);
      xrst = 1'b1;
      #1;
      checkOutput("mid_busy", busy, 0);
      checkOutput("mid_rcv_ack", rcv_ack, 0);
      checkOutput("mid_pixel_in", pixel_in, 0);
      checkOutput("mid_in_rd", in_rd, 0);
      checkOutput("mid_frame_cnt", frame_cnt, 0);
      checkOutput("mid_adjust_from", adjust_from_v, 0);
      checkOutput("mid_out_we", out_we, 0);
      @(negedge clk);
      applyReset();
      w0 = writes;
      repeat (20) @(negedge clk);
      checkOutput("no_writes_after_reset", writes, w0);
      checkOutput("done_count_reset", done_cnt, 2);
      applyStimulus(8'd17, 8'd1, 8'd2, 1'b1);
      waitDone(300);
      @(negedge clk);
      checkOutput("frame_cnt_after_reset", frame_cnt, 1);
      checkOutput("out_mem_3_after_reset", out_mem[3], 70);

      $display("[TB] back-to-back frames");
      applyReset();
      done_cnt = 0;
      for (int f = 0; f < 3; f++) begin
         applyStimulus(8'(f * 40 + 3), 8'(f + 1), 8'(f + 2), 1'b1);
         waitDone(300);
         @(negedge clk);
      end
      checkOutput("frame_cnt_3", frame_cnt, 3);
      checkOutput("done_count_3", done_cnt, 3);
      checkOutput("out_q_drained_3", out_q.size(), 0);
      checkOutput("out_mem_15_b2b", out_mem[15], 148);
      checkOutput("busy_end", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
